// File: rtl/debug_trace_buf.sv
// Instruction-trace capture: registered commit pass-through plus a circular
// history buffer frozen a programmable number of entries after a PC match.
module debug_trace_buf #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_inst_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          insn_i,
    input  logic                     arm_i,
    input  logic                     clear_i,
    input  logic [XLEN-1:0]          trig_pc_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [XLEN-1:0]          pc_o,
    output logic                     valid_inst_o,
    output logic [XLEN-1:0]          rd_pc_o,
    output logic [XLEN-1:0]          rd_insn_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH)-1:0] trig_idx_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [PW-1:0] POST_INIT = PW'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   post_q, post_d;
    logic [PW-1:0]   trig_slot_q, trig_slot_d;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic [XLEN-1:0] rd_pc_q, rd_pc_d;
    logic [XLEN-1:0] rd_insn_q, rd_insn_d;
    logic            rd_valid_q, rd_valid_d;

    logic            wr_en;
    logic            flush;
    logic            trig_hit;
    logic [PW-1:0]   oldest;
    logic [PW-1:0]   rd_addr;

    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] mem_insn [DEPTH];

    assign trig_hit = valid_inst_i && (pc_i == trig_pc_i);

    always_comb begin
        state_d     = state_q;
        post_d      = post_q;
        trig_slot_d = trig_slot_q;
        wr_en       = 1'b0;
        flush       = 1'b0;
        if (clear_i) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end else if (arm_i) begin
            state_d = S_ARMED;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                S_ARMED: begin
                    wr_en = valid_inst_i;
                    if (trig_hit) begin
                        trig_slot_d = wr_ptr_q;
                        post_d      = POST_INIT;
                        state_d     = (POST_TRIG == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_en = valid_inst_i;
                    if (valid_inst_i) begin
                        post_d = post_q - PW'(1);
                        if (post_q == PW'(1)) state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (count_q != FULL) count_d = count_q + CW'(1);
        end
    end

    // A full buffer has count[PW-1:0]==0, so the oldest slot is wr_ptr.
    assign oldest  = wr_ptr_q - count_q[PW-1:0];
    assign rd_addr = oldest + rd_idx_i;

    always_comb begin
        rd_valid_d = {1'b0, rd_idx_i} < count_q;
        rd_pc_d    = '0;
        rd_insn_d  = '0;
        if (rd_valid_d) begin
            rd_pc_d   = mem_pc[rd_addr];
            rd_insn_d = mem_insn[rd_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_pc[wr_ptr_q]   <= pc_i;
            mem_insn[wr_ptr_q] <= insn_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            trig_slot_q <= '0;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            rd_pc_q     <= '0;
            rd_insn_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            trig_slot_q <= trig_slot_d;
            pc_q        <= pc_i;
            valid_q     <= valid_inst_i;
            rd_pc_q     <= rd_pc_d;
            rd_insn_q   <= rd_insn_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign pc_o         = pc_q;
    assign valid_inst_o = valid_q;
    assign rd_pc_o      = rd_pc_q;
    assign rd_insn_o    = rd_insn_q;
    assign rd_valid_o   = rd_valid_q;
    assign count_o      = count_q;
    assign state_o      = state_q;
    assign trig_idx_o   = trig_slot_q - oldest;

endmodule

// File: tb/tb_debug_trace_buf.sv
// Bench for debug_trace_buf: two instances (POST_TRIG=8 and 0) checked each
// cycle against a write-log model, plus hand-computed literal expectations.
module tb_debug_trace_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] insn = '0;
    logic        arm = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [3:0]  rd_idx = '0;

    logic [31:0] pc_o    [2];
    logic        v_o     [2];
    logic [31:0] rpc_o   [2];
    logic [31:0] rins_o  [2];
    logic        rv_o    [2];
    logic [4:0]  cnt_o   [2];
    logic [1:0]  st_o    [2];
    logic [3:0]  tidx_o  [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    debug_trace_buf #(.XLEN(32), .DEPTH(16), .POST_TRIG(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_inst_i(valid), .pc_i(pc),
        .insn_i(insn), .arm_i(arm), .clear_i(clr), .trig_pc_i(trig_pc),
        .rd_idx_i(rd_idx), .pc_o(pc_o[0]), .valid_inst_o(v_o[0]),
        .rd_pc_o(rpc_o[0]), .rd_insn_o(rins_o[0]), .rd_valid_o(rv_o[0]),
        .count_o(cnt_o[0]), .state_o(st_o[0]), .trig_idx_o(tidx_o[0])
    );

    debug_trace_buf #(.XLEN(32), .DEPTH(16), .POST_TRIG(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_inst_i(valid), .pc_i(pc),
        .insn_i(insn), .arm_i(arm), .clear_i(clr), .trig_pc_i(trig_pc),
        .rd_idx_i(rd_idx), .pc_o(pc_o[1]), .valid_inst_o(v_o[1]),
        .rd_pc_o(rpc_o[1]), .rd_insn_o(rins_o[1]), .rd_valid_o(rv_o[1]),
        .count_o(cnt_o[1]), .state_o(st_o[1]), .trig_idx_o(tidx_o[1])
    );

    // Model: a log of every write since the last arm/clear; the buffer is
    // simply the newest min(n,16) log entries.
    int          ptrig [2] = '{8, 0};
    int          mst   [2];
    int          mn    [2];
    int          mtn   [2];
    int          mleft [2];
    logic [31:0] hpc   [2][256];
    logic [31:0] hin   [2][256];
    logic [31:0] e_pc  [2];
    logic        e_v   [2];
    logic        e_rv  [2];
    logic [31:0] e_rpc [2];
    logic [31:0] e_rin [2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            mst[m] = 0; mn[m] = 0; mtn[m] = 0; mleft[m] = 0;
            e_pc[m] = '0; e_v[m] = 1'b0; e_rv[m] = 1'b0;
            e_rpc[m] = '0; e_rin[m] = '0;
        end
    end

    function automatic int mcount(int m);
        return (mn[m] < 16) ? mn[m] : 16;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mwrite(int m);
        if (mn[m] < 256) begin
            hpc[m][mn[m]] = pc;
            hin[m][mn[m]] = insn;
        end
        mn[m]++;
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                mst[m] = 0; mn[m] = 0; mtn[m] = 0; mleft[m] = 0;
                e_pc[m] = '0; e_v[m] = 1'b0; e_rv[m] = 1'b0;
                e_rpc[m] = '0; e_rin[m] = '0;
            end else begin
                int c;
                c = mcount(m);
                e_pc[m] = pc;
                e_v[m] = valid;
                e_rv[m] = int'(rd_idx) < c;
                e_rpc[m] = '0;
                e_rin[m] = '0;
                if (e_rv[m]) begin
                    e_rpc[m] = hpc[m][mn[m] - c + int'(rd_idx)];
                    e_rin[m] = hin[m][mn[m] - c + int'(rd_idx)];
                end
                if (clr) begin
                    mst[m] = 0; mn[m] = 0;
                end else if (arm) begin
                    mst[m] = 1; mn[m] = 0;
                end else if (mst[m] == 1 && valid) begin
                    if (pc == trig_pc) begin
                        mtn[m] = mn[m];
                        mleft[m] = ptrig[m];
                        mst[m] = (ptrig[m] == 0) ? 3 : 2;
                    end
                    mwrite(m);
                end else if (mst[m] == 2 && valid) begin
                    mwrite(m);
                    mleft[m]--;
                    if (mleft[m] == 0) mst[m] = 3;
                end
            end
        end
    endtask

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("pc_o[%0d]", m), pc_o[m], e_pc[m]);
            chk($sformatf("valid_o[%0d]", m), 32'(v_o[m]), 32'(e_v[m]));
            chk($sformatf("count[%0d]", m), 32'(cnt_o[m]), 32'(mcount(m)));
            chk($sformatf("state[%0d]", m), 32'(st_o[m]), 32'(mst[m]));
            chk($sformatf("rd_valid[%0d]", m), 32'(rv_o[m]), 32'(e_rv[m]));
            chk($sformatf("rd_pc[%0d]", m), rpc_o[m], e_rpc[m]);
            chk($sformatf("rd_insn[%0d]", m), rins_o[m], e_rin[m]);
            if (mst[m] == 3)
                chk($sformatf("trig_idx[%0d]", m), 32'(tidx_o[m]),
                    32'(mtn[m] - (mn[m] - mcount(m))));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic commit(logic [31:0] p, logic v);
        pc = p;
        insn = {p[15:0], 16'h0013} ^ 32'h5A00_0000;
        valid = v;
        tick();
        valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        // Reset with stimulus toggling
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            arm = (i == 0);
            valid = 1'b1;
            pc = 32'h40 + 32'(i);
            trig_pc = 32'h40;
            rd_idx = 4'(i);
            tick();
        end
        arm = 1'b0;
        valid = 1'b0;
        chk("rst_state", 32'(st_o[0]), 32'd0);
        chk("rst_count", 32'(cnt_o[0]), 32'd0);
        chk("rst_pc_o", pc_o[0], 32'd0);
        chk("rst_trig_idx", 32'(tidx_o[0]), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) commit(32'h300 + 32'(4 * k), 1'b1);
        chk("idle_count", 32'(cnt_o[0]), 32'd0);

        // Pass-through
        commit(32'h100, 1'b1);
        chk("pt_pc0", pc_o[0], 32'h100);
        chk("pt_v0", 32'(v_o[0]), 32'd1);
        commit(32'h104, 1'b0);
        chk("pt_pc1", pc_o[0], 32'h104);
        chk("pt_v1", 32'(v_o[0]), 32'd0);
        commit(32'h108, 1'b1);
        chk("pt_pc2", pc_o[0], 32'h108);

        // Trigger with defaults
        trig_pc = 32'h040;
        pulse_arm();
        for (int k = 0; k < 64; k++) begin
            rd_idx = 4'(k);
            commit(32'(4 * k), 1'b1);
        end
        chk("trg_state", 32'(st_o[0]), 32'd3);
        chk("trg_count", 32'(cnt_o[0]), 32'd16);
        chk("trg_idx", 32'(tidx_o[0]), 32'd7);
        chk("trg_idx_pt0", 32'(tidx_o[1]), 32'd15);
        rd_idx = 4'd0;
        tick();
        chk("trg_oldest", rpc_o[0], 32'h024);
        rd_idx = 4'd15;
        tick();
        chk("trg_newest", rpc_o[0], 32'h060);
        rd_idx = 4'd7;
        tick();
        chk("trg_entry", rpc_o[0], 32'h040);

        // Wrap without trigger
        trig_pc = 32'hFFFF_FFF0;
        pulse_arm();
        for (int k = 0; k < 40; k++) begin
            rd_idx = 4'(15 - k);
            commit(32'h1000 + 32'(4 * k), 1'b1);
        end
        chk("wrap_state", 32'(st_o[0]), 32'd1);
        chk("wrap_count", 32'(cnt_o[0]), 32'd16);
        rd_idx = 4'd0;
        tick();
        chk("wrap_rd0", rpc_o[0], 32'h1060);
        rd_idx = 4'd15;
        tick();
        chk("wrap_rd15", rpc_o[0], 32'h109C);

        // Trigger on first commit: POST_TRIG=0 instance goes straight to DONE
        trig_pc = 32'h200;
        pulse_arm();
        commit(32'h200, 1'b1);
        chk("pt0_state", 32'(st_o[1]), 32'd3);
        chk("pt0_count", 32'(cnt_o[1]), 32'd1);
        chk("pt0_trig_idx", 32'(tidx_o[1]), 32'd0);
        chk("post_state", 32'(st_o[0]), 32'd2);
        rd_idx = 4'd1;
        commit(32'h204, 1'b1);
        chk("pt0_rd1_valid", 32'(rv_o[1]), 32'd0);
        chk("pt0_rd1_pc", rpc_o[1], 32'd0);
        chk("pt0_frozen", 32'(cnt_o[1]), 32'd1);

        // clear and arm together in POST: clear wins
        clr = 1'b1;
        arm = 1'b1;
        tick();
        clr = 1'b0;
        arm = 1'b0;
        chk("clr_arm_state", 32'(st_o[0]), 32'd0);
        chk("clr_arm_count", 32'(cnt_o[0]), 32'd0);

        // Gaps in POST do not advance the post-trigger counter
        trig_pc = 32'h500;
        pulse_arm();
        commit(32'h4FC, 1'b1);
        commit(32'h500, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            rd_idx = 4'(k);
            commit(32'h600 + 32'(4 * k), 1'b0);
            commit(32'h500 + 32'(4 * k), 1'b1);
            if (k == 7) chk("gap_still_post", 32'(st_o[0]), 32'd2);
        end
        chk("gap_done", 32'(st_o[0]), 32'd3);
        chk("gap_count", 32'(cnt_o[0]), 32'd10);
        chk("gap_trig_idx", 32'(tidx_o[0]), 32'd1);

        // arm in DONE restarts
        pulse_arm();
        chk("rearm_state", 32'(st_o[0]), 32'd1);
        chk("rearm_count", 32'(cnt_o[0]), 32'd0);
        commit(32'h700, 1'b1);

        // Reset mid-capture discards history
        rst_n = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst_mid_state", 32'(st_o[0]), 32'd0);
        chk("rst_mid_count", 32'(cnt_o[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
